// File: rtl/schommel_regelaar.sv
// Baby-rocker controller: steps the rocking setting until stress drops, holds, then winds down.
// Optional SCHOMMEL_ALARM_EN macro adds a fail counter and the latched ALARM state.
module schommel_regelaar #(
  parameter int unsigned WARM_TICKS  = 4,
  parameter int unsigned CALM_TICKS  = 8,
  parameter int unsigned MAX_FAIL    = 12,
  parameter int unsigned STAND_START = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       gedaald,
  input  logic       gelijk,
  output logic [2:0] stand,
  output logic       actief,
  output logic       alarm,
  output logic       klaar
);

  typedef enum logic [2:0] {StIdle, StWarmup, StEval, StHold, StAlarm} state_e;

  localparam int unsigned WarmW = $clog2(WARM_TICKS + 1);
  localparam int unsigned CalmW = $clog2(CALM_TICKS + 1);
  localparam logic [WarmW-1:0] WarmMax = WarmW'(WARM_TICKS);
  localparam logic [CalmW-1:0] CalmMax = CalmW'(CALM_TICKS);
  localparam logic [2:0]       StandStart = 3'(STAND_START);

  state_e           state_q, state_d;
  logic [2:0]       stand_q, stand_d;
  logic             dir_up_q, dir_up_d;
  logic [WarmW-1:0] warm_q, warm_d, warm_inc;
  logic [CalmW-1:0] calm_q, calm_d, calm_inc;
  logic             actief_q, actief_d;
  logic             klaar_q, klaar_d;
  logic [3:0]       stepped;

`ifdef SCHOMMEL_ALARM_EN
  localparam int unsigned FailW = $clog2(MAX_FAIL + 1);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAIL);
  logic [FailW-1:0] fail_q, fail_d, fail_inc;
  logic             alarm_q, alarm_d;
  assign fail_inc = (fail_q == FailMax) ? fail_q : fail_q + 1'b1;
`endif

  assign warm_inc = (warm_q == WarmMax) ? warm_q : warm_q + 1'b1;
  assign calm_inc = (calm_q == CalmMax) ? calm_q : calm_q + 1'b1;

  // {dir_up, stand} after one step; bouncing off either end of 0..7.
  function automatic logic [3:0] step(input logic [2:0] s, input logic up);
    if (up) return (s == 3'd7) ? {1'b0, 3'd6} : {1'b1, s + 3'd1};
    else    return (s == 3'd0) ? {1'b1, 3'd1} : {1'b0, s - 3'd1};
  endfunction

  assign stepped = step(stand_q, gelijk ? dir_up_q : ~dir_up_q);

  always_comb begin
    state_d  = state_q;
    stand_d  = stand_q;
    dir_up_d = dir_up_q;
    warm_d   = warm_q;
    calm_d   = calm_q;
    klaar_d  = 1'b0;
`ifdef SCHOMMEL_ALARM_EN
    fail_d   = fail_q;
`endif
    if (stop) begin
      state_d  = StIdle;
      stand_d  = 3'd0;
      dir_up_d = 1'b1;
      warm_d   = '0;
      calm_d   = '0;
`ifdef SCHOMMEL_ALARM_EN
      fail_d   = '0;
`endif
    end else if (start && (state_q == StIdle || state_q == StAlarm)) begin
      state_d  = StWarmup;
      stand_d  = StandStart;
      dir_up_d = 1'b1;
      warm_d   = '0;
      calm_d   = '0;
`ifdef SCHOMMEL_ALARM_EN
      fail_d   = '0;
`endif
    end else if (tick) begin
      case (state_q)
        StWarmup: begin
          if (warm_inc == WarmMax) begin
            state_d = StEval;
            warm_d  = '0;
          end else begin
            warm_d = warm_inc;
          end
        end
        StEval: begin
          if (gedaald) begin
`ifdef SCHOMMEL_ALARM_EN
            fail_d = '0;
`endif
            if (calm_inc == CalmMax) begin
              state_d = StHold;
              calm_d  = '0;
            end else begin
              calm_d = calm_inc;
            end
          end else begin
            {dir_up_d, stand_d} = stepped;
            calm_d = '0;
`ifdef SCHOMMEL_ALARM_EN
            fail_d = fail_inc;
            if (fail_inc == FailMax) begin
              state_d = StAlarm;
              stand_d = 3'd0;
            end
`endif
          end
        end
        StHold: begin
          if (gedaald || gelijk) begin
            if (stand_q != 3'd0) begin
              stand_d = stand_q - 3'd1;
            end else begin
              state_d  = StIdle;
              klaar_d  = 1'b1;
              dir_up_d = 1'b1;
            end
          end else begin
            stand_d = (stand_q == 3'd7) ? 3'd7 : stand_q + 3'd1;
            state_d = StEval;
            calm_d  = '0;
`ifdef SCHOMMEL_ALARM_EN
            fail_d  = '0;
`endif
          end
        end
        default: ;
      endcase
    end
    actief_d = (state_d == StWarmup) || (state_d == StEval) || (state_d == StHold);
`ifdef SCHOMMEL_ALARM_EN
    alarm_d  = (state_d == StAlarm);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      stand_q  <= 3'd0;
      dir_up_q <= 1'b1;
      warm_q   <= '0;
      calm_q   <= '0;
      actief_q <= 1'b0;
      klaar_q  <= 1'b0;
`ifdef SCHOMMEL_ALARM_EN
      fail_q   <= '0;
      alarm_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stand_q  <= stand_d;
      dir_up_q <= dir_up_d;
      warm_q   <= warm_d;
      calm_q   <= calm_d;
      actief_q <= actief_d;
      klaar_q  <= klaar_d;
`ifdef SCHOMMEL_ALARM_EN
      fail_q   <= fail_d;
      alarm_q  <= alarm_d;
`endif
    end
  end

  assign stand  = stand_q;
  assign actief = actief_q;
  assign klaar  = klaar_q;
`ifdef SCHOMMEL_ALARM_EN
  assign alarm  = alarm_q;
`else
  assign alarm  = 1'b0;
`endif

endmodule

// File: tb/tb_schommel_regelaar.sv
// Directed bench for schommel_regelaar; expectations follow SCHOMMEL_ALARM_EN if defined.
module tb_schommel_regelaar;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, gedaald = 1'b0, gelijk = 1'b0;
  logic [2:0] stand;
  logic       actief, alarm, klaar;
  int         checks = 0;
  int         errors = 0;

  schommel_regelaar dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .start  (start),
    .stop   (stop),
    .gedaald(gedaald),
    .gelijk (gelijk),
    .stand  (stand),
    .actief (actief),
    .alarm  (alarm),
    .klaar  (klaar)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; gedaald = 1'b0; gelijk = 1'b0;
  endtask

  task automatic do_tick(input logic ged, input logic gel);
    tick = 1'b1; gedaald = ged; gelijk = gel;
    cycle();
  endtask

  task automatic check_out(input string name, input logic [2:0] e_stand, input logic e_actief,
                           input logic e_alarm, input logic e_klaar);
    checks++;
    if ({stand, actief, alarm, klaar} !== {e_stand, e_actief, e_alarm, e_klaar}) begin
      errors++;
      $display("FAIL %s: stand/actief/alarm/klaar got %0d/%b/%b/%b expected %0d/%b/%b/%b",
               name, stand, actief, alarm, klaar, e_stand, e_actief, e_alarm, e_klaar);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
  endtask

  task automatic end_session();
    stop = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    #3;
    check_out("reset_async", 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_out("reset_released", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_warmup();
    start = 1'b1;
    cycle();
    check_out("warmup_entry", 3'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b0, (i % 2) == 0);
      check_out($sformatf("warmup_tick%0d", i + 1), 3'd3, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stepping();
    logic [2:0] exp_s [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5};
    for (int i = 0; i < 6; i++) begin
      do_tick(1'b0, 1'b1);
      check_out($sformatf("step_gelijk%0d", i + 1), exp_s[i], 1'b1, 1'b0, 1'b0);
    end
    do_tick(1'b0, 1'b0);
    check_out("step_neither_flip", 3'd6, 1'b1, 1'b0, 1'b0);
    end_session();
    check_out("step_stop", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_calm_hold();
    start_session();
    for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0);
    check_out("hold_entry", 3'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b1);
      check_out($sformatf("hold_down%0d", i + 1), 3'(2 - i), 1'b1, 1'b0, 1'b0);
    end
    do_tick(1'b1, 1'b0);
    check_out("hold_klaar", 3'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    check_out("klaar_one_cycle", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_reeval();
    start_session();
    for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b0);
    check_out("hold_neither_up", 3'd4, 1'b1, 1'b0, 1'b0);
    // Back in EVAL: one gedaald tick must not move stand.
    do_tick(1'b1, 1'b0);
    check_out("reeval_gedaald", 3'd4, 1'b1, 1'b0, 1'b0);
    end_session();
  endtask

  task automatic test_alarm();
    start_session();
    for (int i = 0; i < 11; i++) begin
      do_tick(1'b0, 1'b0);
      check_out($sformatf("fail_tick%0d", i + 1), (i % 2 == 0) ? 3'd2 : 3'd3, 1'b1, 1'b0, 1'b0);
    end
    do_tick(1'b0, 1'b0);
`ifdef SCHOMMEL_ALARM_EN
    check_out("alarm_raised", 3'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 1'b0);
      check_out("alarm_latched", 3'd0, 1'b0, 1'b1, 1'b0);
    end
    start = 1'b1;
    cycle();
    check_out("alarm_restart", 3'd3, 1'b1, 1'b0, 1'b0);
`else
    check_out("no_alarm_tick12", 3'd3, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0);
    check_out("no_alarm_still_eval", 3'd2, 1'b1, 1'b0, 1'b0);
`endif
    end_session();
    check_out("alarm_stop", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    cycle();
    check_out("start_stop_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b1; tick = 1'b1; gelijk = 1'b1;
    cycle();
    check_out("start_ignored_warmup", 3'd3, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; tick = 1'b1; gelijk = 1'b1;
    cycle();
    check_out("stop_beats_tick", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_tick();
    start_session();
    gelijk = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    gelijk = 1'b0;
    check_out("no_tick_hold", 3'd3, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1);
    check_out("tick_after_idle", 3'd4, 1'b1, 1'b0, 1'b0);
    end_session();
  endtask

  task automatic test_reset_in_hold();
    start_session();
    for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b1);
    check_out("pre_reset_hold", 3'd2, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_out("reset_mid_hold", 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    cycle();
    check_out("start_after_reset", 3'd3, 1'b1, 1'b0, 1'b0);
    end_session();
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_stepping();
    test_calm_hold();
    test_hold_reeval();
    test_alarm();
    test_start_stop_idle();
    test_no_tick();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/schommel_regelaar.md
SCHOMMEL_REGELAAR -- requirements
Module: schommel_regelaar

Interface
REQ-001 Parameter WARM_TICKS, default 4: evaluation ticks spent in WARMUP before the first stress evaluation.
REQ-002 Parameter CALM_TICKS, default 8: consecutive gedaald ticks that declare the baby calm.
REQ-003 Parameter MAX_FAIL, default 12: consecutive non-gedaald EVAL ticks that raise alarm.
REQ-004 Parameter STAND_START, default 3: rocking setting loaded on start, range 0..7.
REQ-005 clk  in  1  system clock, all state on rising edge; one clock domain only.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  evaluation strobe, one clk cycle wide (clk12-rate enable); only cycles with tick=1 are evaluated.
REQ-008 start  in  1  one-cycle request to begin a rocking session.
REQ-009 stop  in  1  one-cycle request to abort the session.
REQ-010 gedaald  in  1  stress decreased since last evaluation (from stress block).
REQ-011 gelijk  in  1  stress unchanged since last evaluation (from stress block).
REQ-012 stand  out  3  rocking setting (amplitude/frequency index) for the motor driver.
REQ-013 actief  out  1  high while a session runs (WARMUP, EVAL, HOLD).
REQ-014 alarm  out  1  high in ALARM: rocking does not calm the baby.
REQ-015 klaar  out  1  one-cycle pulse when a session ends normally.

Function
REQ-016 FSM states IDLE, WARMUP, EVAL, HOLD, ALARM; all outputs registered; every change is visible in the cycle after the causing input cycle.
REQ-017 IDLE: stand=0, actief=0; start -> WARMUP, stand=STAND_START, direction=up, counters cleared.
REQ-018 WARMUP: count ticks, ignore gedaald/gelijk; on the WARM_TICKS-th tick -> EVAL.
REQ-019 EVAL tick priority: gedaald over gelijk over neither (stress rose).
REQ-020 EVAL gedaald: stand held, calm counter +1, fail counter cleared; when the calm counter reaches CALM_TICKS -> HOLD, calm counter cleared.
REQ-021 EVAL gelijk: stand steps one position in the current direction; calm counter cleared, fail counter +1.
REQ-022 EVAL neither: direction inverted, then stand steps one position in the new direction; calm counter cleared, fail counter +1.
REQ-023 Step at range end: if stepping would leave 0..7, direction flips and stand steps the other way (7 up -> 6, 0 down -> 1).
REQ-024 Fail counter reaches MAX_FAIL -> ALARM (counter is compiled only with the macro; see REQ-033).
REQ-025 HOLD tick with gedaald or gelijk: stand -1 when stand>0; a tick at stand=0 -> IDLE with klaar=1 for one cycle.
REQ-026 HOLD tick with neither: stand +1, saturating at 7; -> EVAL with counters cleared.
REQ-027 ALARM: stand=0, actief=0, alarm=1, latched until stop or start; start -> WARMUP as in REQ-017.
REQ-028 stop in any non-IDLE state -> IDLE, stand=0, alarm=0, no klaar pulse.
REQ-029 Simultaneous events: stop beats start; start or stop beats tick; start ignored in WARMUP, EVAL and HOLD.
REQ-030 Counters saturate and never wrap; tick absent -> no counter or stand change.

Reset
REQ-031 reset=0 asynchronously forces IDLE, stand=0, actief=0, alarm=0, klaar=0, direction=up, all counters 0, including mid-session.
REQ-032 After reset releases, the first start is accepted on the first rising clk edge.

Configuration
REQ-033 Macro SCHOMMEL_ALARM_EN defined: fail counter and ALARM state present, behaviour per REQ-024/REQ-027; not defined: no fail counter, ALARM unreachable, alarm tied 0, EVAL continues stepping indefinitely.

Verification
REQ-034 Reset, start, 4 ticks -> stand=3 and actief=1 during WARMUP; EVAL entered after the 4th tick.
REQ-035 EVAL, 8 ticks gedaald=1 -> HOLD at stand 3; 3 ticks gelijk -> stand 2,1,0; next tick -> klaar pulse, actief=0.
REQ-036 EVAL from stand 3, up, 6 ticks gelijk=1 -> stand 4,5,6,7,6,5; one tick neither -> direction up, stand 6.
REQ-037 With SCHOMMEL_ALARM_EN, 12 ticks gedaald=0 -> alarm=1, stand=0; without the macro -> alarm stays 0, still EVAL.
REQ-038 start and stop in the same cycle while IDLE -> remains IDLE; reset pulse in HOLD at stand 2 -> all outputs 0 immediately.
